tmds_channel_decoder: RTL and testbench

TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

---
 rtl/tmds_channel_decoder_if.sv | 15 +
 rtl/tmds_channel_decoder.sv | 166 ++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmds_channel_decoder_if.sv
// TMDS channel decoder bus: raw deserialized word in, decoded symbol and alignment status out.
interface tmds_channel_decoder_if;
   logic [9:0] tmds_raw;
   logic [7:0] vd;
   logic [1:0] cd;
   logic       vde;
   logic       locked;
   logic [3:0] offset;

   // Source side: drives raw words, observes decoder results
   modport master (output tmds_raw, input vd, cd, vde, locked, offset);

   // Decoder side
   modport slave (input tmds_raw, output vd, cd, vde, locked, offset);
endinterface

// File: rtl/tmds_channel_decoder.sv
// Single-channel TMDS decoder: bit-slip word alignment on control tokens, then
// token / video decode in a two-register pipeline behind the raw-word register.
module tmds_channel_decoder #(
   parameter int unsigned TOKEN_RUN      = 8,
   parameter int unsigned SEARCH_TIMEOUT = 1024,
   parameter int unsigned LOCK_TIMEOUT   = 2048
) (
   input  logic                   clk,
   input  logic                   rst_n,
   tmds_channel_decoder_if.slave  tmds
);

   localparam int unsigned RUN_W   = $clog2(TOKEN_RUN + 1);
   localparam int unsigned TMR_MAX = (SEARCH_TIMEOUT > LOCK_TIMEOUT) ? SEARCH_TIMEOUT : LOCK_TIMEOUT;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [0:0] ST_SEARCH = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   localparam logic [3:0] OFFSET_MAX = 4'd9;

   logic [0:0]       state_q,    state_d;
   logic [3:0]       offset_q,   offset_d;
   logic [TMR_W-1:0] timer_q,    timer_d;
   logic [RUN_W-1:0] run_q,      run_d;
   logic [9:0]       raw_prev_q;
   logic [9:0]       word_q,     word_d;
   logic [7:0]       vd_q,       vd_d;
   logic [1:0]       cd_q,       cd_d;
   logic             vde_q,      vde_d;
   logic             locked_q,   locked_d;

   logic [18:0]      window_c;
   logic             tok_c;
   logic [1:0]       tok_cd_c;
   logic [7:0]       dat_c;
   logic [7:0]       vd_dec_c;
   logic [3:0]       offset_adv_c;

   // Bit-slip mux: pick the 10-bit word starting at the current offset
   always_comb begin
      window_c = {tmds.tmds_raw[8:0], raw_prev_q};
      word_d   = window_c[9:0];
      for (int k = 1; k < 10; k++) begin
         if (offset_q == 4'(k)) begin
            word_d = window_c[k +: 10];
         end
      end
   end

   // Control token classification of the aligned word
   always_comb begin
      tok_c    = 1'b1;
      tok_cd_c = 2'b00;
      case (word_q)
         10'b1101010100: tok_cd_c = 2'b00;
         10'b0010101011: tok_cd_c = 2'b01;
         10'b0101010100: tok_cd_c = 2'b10;
         10'b1010101011: tok_cd_c = 2'b11;
         default:        tok_c    = 1'b0;
      endcase
   end

   // Video data decode: undo optional inversion, then XOR/XNOR chain
   always_comb begin
      dat_c       = word_q[9] ? ~word_q[7:0] : word_q[7:0];
      vd_dec_c    = '0;
      vd_dec_c[0] = dat_c[0];
      for (int i = 1; i < 8; i++) begin
         vd_dec_c[i] = word_q[8] ? (dat_c[i] ^ dat_c[i-1]) : ~(dat_c[i] ^ dat_c[i-1]);
      end
   end

   // Alignment FSM next state and stage-2 output selection
   always_comb begin
      state_d      = state_q;
      offset_d     = offset_q;
      timer_d      = timer_q;
      run_d        = run_q;
      vd_d         = vd_q;
      cd_d         = cd_q;
      vde_d        = vde_q;
      offset_adv_c = (offset_q == OFFSET_MAX) ? 4'd0 : offset_q + 4'd1;

      case (state_q)
         ST_SEARCH: begin
            vd_d  = 8'd0;
            cd_d  = 2'b00;
            vde_d = 1'b0;
            // Lock takes priority over a coincident search timeout
            if (tok_c && (run_q == RUN_W'(TOKEN_RUN - 1))) begin
               state_d = ST_LOCKED;
               timer_d = '0;
               run_d   = '0;
            end else if (timer_q == TMR_W'(SEARCH_TIMEOUT - 1)) begin
               offset_d = offset_adv_c;
               timer_d  = '0;
               run_d    = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
               run_d   = tok_c ? run_q + RUN_W'(1) : '0;
            end
         end

         ST_LOCKED: begin
            if (tok_c) begin
               vde_d   = 1'b0;
               cd_d    = tok_cd_c;
               vd_d    = 8'd0;
               timer_d = '0;
            end else begin
               vde_d = 1'b1;
               vd_d  = vd_dec_c;
               if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                  state_d  = ST_SEARCH;
                  offset_d = offset_adv_c;
                  timer_d  = '0;
                  run_d    = '0;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
         end

         default: begin
            state_d = ST_SEARCH;
         end
      endcase

      locked_d = (state_d == ST_LOCKED);
   end

   // State, counters and pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_SEARCH;
         offset_q   <= 4'd0;
         timer_q    <= '0;
         run_q      <= '0;
         raw_prev_q <= 10'd0;
         word_q     <= 10'd0;
         vd_q       <= 8'd0;
         cd_q       <= 2'b00;
         vde_q      <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         offset_q   <= offset_d;
         timer_q    <= timer_d;
         run_q      <= run_d;
         raw_prev_q <= tmds.tmds_raw;
         word_q     <= word_d;
         vd_q       <= vd_d;
         cd_q       <= cd_d;
         vde_q      <= vde_d;
         locked_q   <= locked_d;
      end
   end

   assign tmds.vd     = vd_q;
   assign tmds.cd     = cd_q;
   assign tmds.vde    = vde_q;
   assign tmds.locked = locked_q;
   assign tmds.offset = offset_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: random encoded video/control stream, behavioural model, pinned scenarios.
module tb_tmds_channel_decoder;

   localparam int unsigned TOKEN_RUN      = 8;
   localparam int unsigned SEARCH_TIMEOUT = 100;
   localparam int unsigned LOCK_TIMEOUT   = 128;
   localparam int          HIST           = 16384;

   localparam logic [9:0] T00  = 10'b1101010100;
   localparam logic [9:0] T10  = 10'b0101010100;
   localparam logic [9:0] DATW = 10'b0100000000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   tmds_channel_decoder_if tif ();

   tmds_channel_decoder #(
      .TOKEN_RUN      (TOKEN_RUN),
      .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
      .LOCK_TIMEOUT   (LOCK_TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .tmds  (tif)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- stream source ----------------
   logic        src_ctrl [HIST];
   logic [1:0]  src_cd   [HIST];
   logic [7:0]  src_byte [HIST];
   int          gen_idx  = 0;
   bit          seg_ctrl = 1'b0;
   int          seg_left = 0;
   logic [1:0]  seg_cd   = 2'b00;
   logic [9:0]  prev_enc = 10'd0;
   int          rot      = 0;
   int          cur_idx  = -1;

   function automatic logic [9:0] token_of(input logic [1:0] c);
      case (c)
         2'b00:   return 10'b1101010100;
         2'b01:   return 10'b0010101011;
         2'b10:   return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   function automatic bit is_token(input logic [9:0] w, output logic [1:0] c);
      for (int i = 0; i < 4; i++) begin
         if (w == token_of(2'(i))) begin
            c = 2'(i);
            return 1'b1;
         end
      end
      c = 2'b00;
      return 1'b0;
   endfunction

   // Transition-minimising TMDS encoder with free choice of the inversion bit
   function automatic logic [9:0] encode_byte(input logic [7:0] d, input bit inv);
      int         n1;
      bit         use_xnor;
      logic [7:0] qm;
      n1       = $countones(d);
      use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++) begin
         qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      end
      return {inv, ~use_xnor, inv ? ~qm : qm};
   endfunction

   function automatic logic [7:0] decode_word(input logic [9:0] q);
      logic [7:0] d;
      logic [7:0] v;
      d    = q[9] ? ~q[7:0] : q[7:0];
      v[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         v[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
      return v;
   endfunction

   task automatic gen_restart_ctrl(input int r);
      seg_ctrl = 1'b1;
      seg_left = 16;
      seg_cd   = 2'($urandom_range(0, 3));
      rot      = r;
      prev_enc = 10'd0;
   endtask

   task automatic gen_next(output logic [9:0] raw, output int idx);
      logic [9:0]  enc;
      logic [7:0]  b;
      logic [1:0]  tc;
      logic [19:0] pair;
      if (seg_left == 0) begin
         seg_ctrl = !seg_ctrl;
         seg_left = seg_ctrl ? int'($urandom_range(14, 20)) : int'($urandom_range(20, 35));
         if (seg_ctrl) seg_cd = 2'($urandom_range(0, 3));
      end
      b = 8'd0;
      if (seg_ctrl) begin
         enc = token_of(seg_cd);
      end else begin
         do begin
            b   = 8'($urandom);
            enc = encode_byte(b, 1'($urandom_range(0, 1)));
         end while (is_token(enc, tc));
      end
      seg_left--;
      idx           = gen_idx % HIST;
      src_ctrl[idx] = seg_ctrl;
      src_cd[idx]   = seg_cd;
      src_byte[idx] = b;
      gen_idx++;
      pair = {enc, prev_enc};
      raw  = (rot == 0) ? enc : 10'(pair >> (10 - rot));
      prev_enc = enc;
   endtask

   task automatic step_gen();
      logic [9:0] raw;
      int         idx;
      gen_next(raw, idx);
      tif.tmds_raw = raw;
      cur_idx      = idx;
      @(negedge clk);
   endtask

   task automatic step_raw(input logic [9:0] w);
      tif.tmds_raw = w;
      cur_idx      = -1;
      @(negedge clk);
   endtask

   // ---------------- behavioural model ----------------
   logic [9:0] m_prev, m_q1;
   bit         m_lk;
   int         m_off, m_tim, m_run, lock_age, p1, p2, p3;
   logic [7:0] e_vd;
   logic [1:0] e_cd;
   bit         e_vde;

   task automatic model_reset();
      m_prev = 10'd0; m_q1 = 10'd0; m_lk = 1'b0;
      m_off = 0; m_tim = 0; m_run = 0; lock_age = 0;
      p1 = -1; p2 = -1; p3 = -1;
      e_vd = 8'd0; e_cd = 2'b00; e_vde = 1'b0;
   endtask

   task automatic model_step();
      logic [19:0] win;
      logic [9:0]  al;
      logic [1:0]  tc;
      bit          tk;
      win = {tif.tmds_raw, m_prev};
      al  = 10'(win >> m_off);
      tk  = is_token(m_q1, tc);
      if (m_lk) begin
         if (tk) begin
            e_vde = 1'b0; e_cd = tc; e_vd = 8'd0;
         end else begin
            e_vde = 1'b1; e_vd = decode_word(m_q1);
         end
      end else begin
         e_vde = 1'b0; e_cd = 2'b00; e_vd = 8'd0;
      end
      if (!m_lk) begin
         m_run = tk ? m_run + 1 : 0;
         if (m_run == int'(TOKEN_RUN)) begin
            m_lk = 1'b1; m_run = 0; m_tim = 0;
         end else if (m_tim == int'(SEARCH_TIMEOUT) - 1) begin
            m_off = (m_off == 9) ? 0 : m_off + 1; m_tim = 0; m_run = 0;
         end else begin
            m_tim++;
         end
      end else begin
         if (tk) begin
            m_tim = 0;
         end else if (m_tim == int'(LOCK_TIMEOUT) - 1) begin
            m_lk = 1'b0; m_off = (m_off == 9) ? 0 : m_off + 1; m_tim = 0; m_run = 0;
         end else begin
            m_tim++;
         end
      end
      m_q1     = al;
      m_prev   = tif.tmds_raw;
      p3       = p2; p2 = p1; p1 = cur_idx;
      lock_age = m_lk ? lock_age + 1 : 0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // Per-cycle comparison against the model and against the encoder source
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("vd",     int'(tif.vd),     int'(e_vd));
            check("cd",     int'(tif.cd),     int'(e_cd));
            check("vde",    int'(tif.vde),    int'(e_vde));
            check("locked", int'(tif.locked), int'(m_lk));
            check("offset", int'(tif.offset), m_off);
            if (lock_age >= 2 && p3 >= 0) begin
               if (src_ctrl[p3]) begin
                  check("src_vde", int'(tif.vde), 0);
                  check("src_cd",  int'(tif.cd),  int'(src_cd[p3]));
               end else begin
                  check("src_vde", int'(tif.vde), 1);
                  check("src_vd",  int'(tif.vd),  int'(src_byte[p3]));
               end
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_vd"},     int'(tif.vd),     0);
      check({tag, "_cd"},     int'(tif.cd),     0);
      check({tag, "_vde"},    int'(tif.vde),    0);
      check({tag, "_locked"}, int'(tif.locked), 0);
      check({tag, "_offset"}, int'(tif.offset), 0);
   endtask

   // Release reset with a control period starting; lock must rise exactly 2+TOKEN_RUN edges later
   task automatic release_and_pin_lock(input string tag);
      logic [9:0] raw;
      int         idx;
      int         e;
      gen_restart_ctrl(0);
      gen_next(raw, idx);
      tif.tmds_raw = raw;
      cur_idx      = idx;
      rst_n        = 1'b1;
      @(negedge clk);
      e = 1;
      repeat (11) begin
         if (e == int'(TOKEN_RUN) + 1) check({tag, "_lock_early"}, int'(tif.locked), 0);
         if (e == int'(TOKEN_RUN) + 2) begin
            check({tag, "_lock_rise"}, int'(tif.locked), 1);
            check({tag, "_lock_off"},  int'(tif.offset), 0);
         end
         step_gen();
         e++;
      end
   endtask

   logic [9:0] pat     [6];
   int         x_vde   [4];
   int         x_cd    [4];
   int         x_vd    [4];

   initial begin
      int  last_off;
      int  last_e;
      int  e;
      bit  found;

      tif.tmds_raw = 10'd0;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");

      // Aligned stream, lock timing and random traffic
      release_and_pin_lock("aligned");
      repeat (400) step_gen();

      // Hand-decoded words
      pat = '{T00, T10, 10'b0100000000, 10'b1011111111, T10, T10};
      x_vde = '{0, 0, 1, 1};
      x_cd  = '{0, 2, 2, 2};
      x_vd  = '{0, 0, 8'h00, 8'hFE};
      check("pre_fixed_locked", int'(tif.locked), 1);
      for (int k = 0; k < 6; k++) begin
         step_raw(pat[k]);
         if (k >= 2) begin
            check($sformatf("fixed%0d_vde", k - 2), int'(tif.vde), x_vde[k-2]);
            check($sformatf("fixed%0d_cd",  k - 2), int'(tif.cd),  x_cd[k-2]);
            check($sformatf("fixed%0d_vd",  k - 2), int'(tif.vd),  x_vd[k-2]);
         end
      end
      repeat (100) step_gen();

      // Asynchronous reset while locked, then relock from offset 0
      check("pre_rst_locked", int'(tif.locked), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      @(negedge clk);
      release_and_pin_lock("relock");
      repeat (200) step_gen();

      // Lock loss after LOCK_TIMEOUT token-free words
      check("pre_loss_locked", int'(tif.locked), 1);
      check("pre_loss_offset", int'(tif.offset), 0);
      for (int k = 0; k <= int'(LOCK_TIMEOUT) + 6; k++) begin
         step_raw((k < 4) ? T00 : DATW);
         if (k == int'(LOCK_TIMEOUT) + 4) check("loss_still_locked", int'(tif.locked), 1);
         if (k == int'(LOCK_TIMEOUT) + 5) begin
            check("loss_locked", int'(tif.locked), 0);
            check("loss_offset", int'(tif.offset), 1);
            check("loss_vde_last", int'(tif.vde), 1);
         end
         if (k == int'(LOCK_TIMEOUT) + 6) check("loss_vde_off", int'(tif.vde), 0);
      end

      // Offset wrap from 9 to 0 with no tokens
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         step_raw(DATW);
         if (tif.offset == 4'd9) found = 1'b1;
      end
      check("wait_off9", int'(found), 1);
      for (int j = 1; j <= int'(SEARCH_TIMEOUT); j++) begin
         step_raw(DATW);
         if (j == int'(SEARCH_TIMEOUT) - 1) check("wrap_hold9", int'(tif.offset), 9);
         if (j == int'(SEARCH_TIMEOUT))     check("wrap_to0",   int'(tif.offset), 0);
      end

      // Stream rotated by 3 bits: offset walks 0..3 then locks
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      check("rot_rst_offset", int'(tif.offset), 0);
      gen_restart_ctrl(3);
      rst_n    = 1'b1;
      last_off = 0;
      last_e   = 0;
      e        = 0;
      found    = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         step_gen();
         e++;
         if (int'(tif.offset) != last_off) begin
            check("rot_step", int'(tif.offset), last_off + 1);
            check("rot_interval", e - last_e, int'(SEARCH_TIMEOUT));
            last_off = int'(tif.offset);
            last_e   = e;
         end
         if (tif.locked) found = 1'b1;
      end
      check("rot_locked", int'(found), 1);
      check("rot_offset", int'(tif.offset), 3);
      repeat (300) step_gen();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      n_bad++;
      $display("FAIL watchdog: actual still running, required finish before %0t", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
